decode_scoreboard: RTL and testbench
====================================

Name: decode_scoreboard

Overview:
- Parametrised successor to the single-issue decode operand/hazard logic.
- Tracks in-flight register writes with a per-register busy bit and a latency countdown, so multi-cycle producers (load, mul, div) are covered.
- Forwards operands from NFWD ordered bypass ports and registers the result into the decode→execute pipeline register.
- Sits between fetch and execute; replaces the fixed E/M/D bypass-and-bubble scheme.

Parameters:
- XLEN, 64, data width.
- NREG, 32, architectural registers; register 0 is hard-wired zero.
- NFWD, 3, bypass ports; index 0 is the youngest and has highest priority.
- LATW, 4, width of the per-register latency countdown.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch output valid
- in_pc  in  XLEN  fetch PC
- in_instr  in  32  instruction; rs1=[19:15], rs2=[24:20], rd=[11:7]
- in_regwrite  in  1  decoded: instruction writes rd
- in_lat  in  LATW  decoded: cycles after issue until result appears on a bypass port
- rf_q1, rf_q2  in  XLEN  register-file read data for rs1/rs2
- fwd_valid  in  NFWD  bypass entry valid
- fwd_dst  in  NFWD×5  bypass destination register
- fwd_ready  in  NFWD  bypass data is final (0 for a load still in memory stage)
- fwd_data  in  NFWD×XLEN  bypass data
- wb_valid  in  1  writeback retiring a write
- wb_dst  in  5  writeback register
- flush  in  1  branch redirect; kill the instruction entering execute
- hold  in  1  downstream stall (execute/memory busy)
- stall_d  out  1  decode stall to fetch
- out_valid  out  1  registered: instruction valid to execute
- out_pc  out  XLEN  registered PC
- out_instr  out  32  registered instruction
- out_dst  out  5  registered rd
- out_op1, out_op2  out  XLEN  registered forwarded operands
- stall_cnt  out  32  saturating count of stall_d cycles

Behaviour:
- Reset (asynchronous): busy[*]=0, cnt[*]=0, out_valid=0, out_pc=0, out_instr=0, out_dst=0, out_op1=0, out_op2=0, stall_cnt=0.
- Operand select, per operand (combinational):
  - rs==0 → 0.
  - Otherwise the lowest index i with fwd_valid[i] && fwd_dst[i]==rs → fwd_data[i].
  - Otherwise rf_q.
- Per-operand hazard when rs!=0 and either:
  - (a) lowest matching bypass has fwd_ready=0; or
  - (b) busy[rs] && (cnt[rs]!=0 || no matching bypass).
- stall_d = in_valid && (hazard1 || hazard2) && !flush. Combinational.
- issue = in_valid && !stall_d && !hold && !flush.
- Scoreboard update, per register r, each cycle:
  - If issue && in_regwrite && rd==r && r!=0: busy←1, cnt←in_lat. Issue wins over a same-cycle writeback to r.
  - Else if wb_valid && wb_dst==r: busy←0, cnt←0.
  - Else if busy && cnt!=0: cnt←cnt−1.
  - Register 0 is never busy.
- Pipeline register:
  - hold=1: all out_* keep their values, except flush, which still forces out_valid←0.
  - hold=0: out_valid←issue; out_pc, out_instr, out_op1, out_op2 load from the inputs and operand select; out_dst←rd, or 0 if !in_regwrite.
  - A bubble (stall_d or flush) updates payload fields but out_valid=0.
- Latency: one cycle from accepted input to out_*.
- in_lat=0: the result must be on a bypass port the next cycle. Stall then depends only on bypass match and readiness.
- stall_cnt increments when stall_d=1 and saturates at 2^32−1.
- Reset mid-operation clears all pending writes. The environment must not deliver writebacks from pre-reset instructions.

Test Plan:
- No hazards: three independent ADDs (rs1=1,rs2=2, rf_q1=5, rf_q2=7) → out_valid=1 one cycle later, out_op1=5, out_op2=7, stall_d=0.
- Priority forwarding: fwd[0] and fwd[2] both target x3 with data 0xAA and 0xBB, ready=1; instr reads rs1=3 → out_op1=0xAA.
- Load-use: fwd[0] targets x4 with ready=0; instr uses rs2=4 → stall_d=1, out_valid=0. Next cycle ready=1, data 0x10 → issue, out_op2=0x10, stall_cnt=1.
- Multi-cycle producer:
  - Issue MUL to x5 with in_lat=3; the consumer of x5 stalls exactly 3 cycles.
  - Cycle 4, with fwd match ready → issues.
  - wb_valid x5 → busy[5]=0.
- Same-cycle issue and writeback to x6 → busy[6]=1 with the new cnt. Reads of x0 always return 0 and never stall, even with fwd_dst=0 valid.
- hold=1 freezes out_*; flush with hold=1 → out_valid=0. Assert reset mid-stall → all outputs zero immediately and busy cleared.

Source files
------------

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : decode_scoreboard
// Purpose  : Decode-stage operand forwarding and hazard scoreboard. Tracks
//            in-flight register writes (busy bit + latency countdown per
//            register), selects operands from NFWD priority-ordered bypass
//            ports, and registers the result into the decode->execute stage.
// Ports    :
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid/in_pc/in_instr     instruction from fetch (rs1/rs2/rd fields)
//   in_regwrite, in_lat         decoded write-enable and producer latency
//   rf_q1, rf_q2                register-file read data for rs1/rs2
//   fwd_valid/dst/ready/data    bypass ports, index 0 youngest
//   wb_valid, wb_dst            writeback retiring a register write
//   flush, hold                 redirect kill / downstream stall
//   stall_d                     combinational stall back to fetch
//   out_*                       registered decode->execute payload
//   stall_cnt                   saturating count of stall_d cycles
// Revision : 1.0 - initial release
// ============================================================================
module decode_scoreboard #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NFWD = 3,
  parameter int LATW = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_instr,
  input  logic                 in_regwrite,
  input  logic [LATW-1:0]      in_lat,
  input  logic [XLEN-1:0]      rf_q1,
  input  logic [XLEN-1:0]      rf_q2,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*5-1:0]    fwd_dst,
  input  logic [NFWD-1:0]      fwd_ready,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_dst,
  input  logic                 flush,
  input  logic                 hold,
  output logic                 stall_d,
  output logic                 out_valid,
  output logic [XLEN-1:0]      out_pc,
  output logic [31:0]          out_instr,
  output logic [4:0]           out_dst,
  output logic [XLEN-1:0]      out_op1,
  output logic [XLEN-1:0]      out_op2,
  output logic [31:0]          stall_cnt
);

  // Instruction fields
  logic [4:0] w_rs1, w_rs2, w_rd;
  assign w_rs1 = in_instr[19:15];
  assign w_rs2 = in_instr[24:20];
  assign w_rd  = in_instr[11:7];

  // Scoreboard state
  logic [NREG-1:0] busy_q, busy_d;
  logic [LATW-1:0] cnt_q [NREG];
  logic [LATW-1:0] cnt_d [NREG];

  // Pipeline register state
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [4:0]      out_dst_q, out_dst_d;
  logic [XLEN-1:0] out_op1_q, out_op1_d;
  logic [XLEN-1:0] out_op2_q, out_op2_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;

  // Bypass match results per operand
  logic            w_m1, w_m2, w_rdy1, w_rdy2;
  logic [XLEN-1:0] w_fd1, w_fd2;
  logic [XLEN-1:0] w_op1, w_op2;
  logic            w_haz1, w_haz2, w_issue;

  // Scan from oldest to youngest so the lowest matching index is the last
  // assignment and therefore wins.
  always_comb begin
    w_m1   = 1'b0;
    w_m2   = 1'b0;
    w_rdy1 = 1'b0;
    w_rdy2 = 1'b0;
    w_fd1  = '0;
    w_fd2  = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_dst[i*5 +: 5] == w_rs1)) begin
        w_m1   = 1'b1;
        w_rdy1 = fwd_ready[i];
        w_fd1  = fwd_data[i*XLEN +: XLEN];
      end
      if (fwd_valid[i] && (fwd_dst[i*5 +: 5] == w_rs2)) begin
        w_m2   = 1'b1;
        w_rdy2 = fwd_ready[i];
        w_fd2  = fwd_data[i*XLEN +: XLEN];
      end
    end
  end

  assign w_op1 = (w_rs1 == 5'd0) ? '0 : (w_m1 ? w_fd1 : rf_q1);
  assign w_op2 = (w_rs2 == 5'd0) ? '0 : (w_m2 ? w_fd2 : rf_q2);

  // A busy register can only be consumed once its countdown has expired and
  // the producer is actually visible on a bypass port.
  assign w_haz1 = (w_rs1 != 5'd0) &&
                  ((w_m1 && !w_rdy1) ||
                   (busy_q[w_rs1] && ((cnt_q[w_rs1] != '0) || !w_m1)));
  assign w_haz2 = (w_rs2 != 5'd0) &&
                  ((w_m2 && !w_rdy2) ||
                   (busy_q[w_rs2] && ((cnt_q[w_rs2] != '0) || !w_m2)));

  assign stall_d = in_valid && (w_haz1 || w_haz2) && !flush;
  assign w_issue = in_valid && !stall_d && !hold && !flush;

  // Scoreboard next state; a new issue to r takes precedence over a
  // same-cycle writeback of the older value.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        busy_d[r] = 1'b0;
        cnt_d[r]  = '0;
      end else if (w_issue && in_regwrite && (w_rd == 5'(r))) begin
        busy_d[r] = 1'b1;
        cnt_d[r]  = in_lat;
      end else if (wb_valid && (wb_dst == 5'(r))) begin
        busy_d[r] = 1'b0;
        cnt_d[r]  = '0;
      end else if (busy_q[r] && (cnt_q[r] != '0)) begin
        cnt_d[r]  = cnt_q[r] - LATW'(1);
      end
    end
  end

  // Pipeline register next state; flush kills validity even while held.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_dst_d   = out_dst_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    if (hold) begin
      if (flush) begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = w_issue;
      out_pc_d    = in_pc;
      out_instr_d = in_instr;
      out_dst_d   = in_regwrite ? w_rd : 5'd0;
      out_op1_d   = w_op1;
      out_op2_d   = w_op2;
    end
  end

  assign stall_cnt_d = (stall_d && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1
                                                        : stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= '0;
      cnt_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_dst_q   <= '0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_dst_q   <= out_dst_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;
  assign out_dst   = out_dst_q;
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_scoreboard
// Purpose  : Self-checking bench for decode_scoreboard. Directed scenarios
//            followed by randomized traffic, all compared against a
//            reference model that tracks pending writes by due cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_scoreboard;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NFWD = 3;
  localparam int LATW = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [XLEN-1:0]      in_pc;
  logic [31:0]          in_instr;
  logic                 in_regwrite;
  logic [LATW-1:0]      in_lat;
  logic [XLEN-1:0]      rf_q1, rf_q2;
  logic [NFWD-1:0]      fwd_valid, fwd_ready;
  logic [NFWD*5-1:0]    fwd_dst;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 wb_valid;
  logic [4:0]           wb_dst;
  logic                 flush, hold;
  logic                 stall_d, out_valid;
  logic [XLEN-1:0]      out_pc, out_op1, out_op2;
  logic [31:0]          out_instr, stall_cnt;
  logic [4:0]           out_dst;

  decode_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD), .LATW(LATW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_regwrite(in_regwrite), .in_lat(in_lat),
    .rf_q1(rf_q1), .rf_q2(rf_q2), .fwd_valid(fwd_valid), .fwd_dst(fwd_dst),
    .fwd_ready(fwd_ready), .fwd_data(fwd_data), .wb_valid(wb_valid),
    .wb_dst(wb_dst), .flush(flush), .hold(hold), .stall_d(stall_d),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_dst(out_dst), .out_op1(out_op1), .out_op2(out_op2),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: a register is pending until writeback; its producer
  // result is not yet available before cycle m_due.
  bit          m_busy [NREG];
  int          m_due  [NREG];
  int          cyc = 0;
  bit          m_ov;
  logic [63:0] m_pc, m_op1, m_op2;
  logic [31:0] m_instr, m_stall;
  logic [4:0]  m_dst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_busy[r] = 1'b0;
      m_due[r]  = 0;
    end
    m_ov = 1'b0; m_pc = '0; m_op1 = '0; m_op2 = '0;
    m_instr = '0; m_stall = '0; m_dst = '0;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  task automatic set_fwd(input int i, input bit v, input logic [4:0] d,
                         input bit rdy, input logic [63:0] data);
    fwd_valid[i]            = v;
    fwd_dst[i*5 +: 5]       = d;
    fwd_ready[i]            = rdy;
    fwd_data[i*XLEN +: XLEN] = data;
  endtask

  task automatic idle();
    in_valid = 0; in_pc = '0; in_instr = '0; in_regwrite = 0; in_lat = '0;
    rf_q1 = '0; rf_q2 = '0; fwd_valid = '0; fwd_dst = '0; fwd_ready = '0;
    fwd_data = '0; wb_valid = 0; wb_dst = '0; flush = 0; hold = 0;
  endtask

  // Reference operand value and hazard for one source register.
  task automatic sel(input logic [4:0] rs, input logic [63:0] rfq,
                     output logic [63:0] v, output bit haz);
    int hit = -1;
    for (int i = 0; i < NFWD; i++)
      if (hit < 0 && fwd_valid[i] && fwd_dst[i*5 +: 5] == rs) hit = i;
    if (rs == 5'd0) begin
      v = '0; haz = 1'b0;
      return;
    end
    v   = (hit >= 0) ? fwd_data[hit*XLEN +: XLEN] : rfq;
    haz = (hit >= 0 && !fwd_ready[hit]) || (m_busy[rs] && (cyc < m_due[rs] || hit < 0));
  endtask

  // One clock cycle with the currently driven inputs, checked before and
  // after the edge.
  task automatic step();
    logic [63:0] e1, e2;
    bit h1, h2, est, eiss;
    logic [4:0] rd;
    #1;
    rd = in_instr[11:7];
    sel(in_instr[19:15], rf_q1, e1, h1);
    sel(in_instr[24:20], rf_q2, e2, h2);
    est  = in_valid && (h1 || h2) && !flush;
    eiss = in_valid && !est && !hold && !flush;
    chk("stall_d", stall_d, est);
    @(posedge clk);
    if (est && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    for (int r = 1; r < NREG; r++) begin
      if (eiss && in_regwrite && rd == 5'(r)) begin
        m_busy[r] = 1'b1;
        m_due[r]  = cyc + 1 + int'(in_lat);
      end else if (wb_valid && wb_dst == 5'(r)) begin
        m_busy[r] = 1'b0;
      end
    end
    if (hold) begin
      if (flush) m_ov = 1'b0;
    end else begin
      m_ov = eiss; m_pc = in_pc; m_instr = in_instr;
      m_dst = in_regwrite ? rd : 5'd0; m_op1 = e1; m_op2 = e2;
    end
    cyc++;
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_pc", out_pc, m_pc);
    chk("out_instr", out_instr, m_instr);
    chk("out_dst", out_dst, m_dst);
    chk("out_op1", out_op1, m_op1);
    chk("out_op2", out_op2, m_op2);
    chk("stall_cnt", stall_cnt, m_stall);
  endtask

  initial begin
    int n;
    idle();
    model_reset();
    reset = 1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_op1", out_op1, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    #11 reset = 0;

    // Independent ADDs
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_pc = 64'h100 + 64'(4 * k); in_instr = mk(5'd1, 5'd2, 5'(10 + k));
      in_regwrite = 1; rf_q1 = 64'd5; rf_q2 = 64'd7;
      step();
      chk("add_valid", out_valid, 1);
      chk("add_op1", out_op1, 5);
      chk("add_op2", out_op2, 7);
    end

    // Priority forwarding; x0 never forwards or stalls even with a match
    idle();
    in_valid = 1; in_pc = 64'h200; in_instr = mk(5'd3, 5'd0, 5'd0);
    set_fwd(0, 1, 5'd3, 1, 64'hAA);
    set_fwd(1, 1, 5'd0, 0, 64'hCC);
    set_fwd(2, 1, 5'd3, 1, 64'hBB);
    step();
    chk("prio_op1", out_op1, 64'hAA);
    chk("x0_op2", out_op2, 0);

    // Load-use
    idle();
    in_valid = 1; in_pc = 64'h300; in_instr = mk(5'd0, 5'd4, 5'd8); in_regwrite = 1;
    set_fwd(0, 1, 5'd4, 0, 64'h0);
    step();
    chk("lu_bubble", out_valid, 0);
    set_fwd(0, 1, 5'd4, 1, 64'h10);
    step();
    chk("lu_op2", out_op2, 64'h10);
    chk("lu_stall_cnt", stall_cnt, 1);

    // Multi-cycle producer into x5, latency 3
    idle();
    in_valid = 1; in_pc = 64'h400; in_instr = mk(5'd1, 5'd2, 5'd5);
    in_regwrite = 1; in_lat = 4'd3;
    step();
    idle();
    in_valid = 1; in_pc = 64'h404; in_instr = mk(5'd5, 5'd0, 5'd0);
    set_fwd(1, 1, 5'd5, 1, 64'h55);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (!stall_d) break;
      n++;
      step();
    end
    chk("mul_stall_cycles", 64'(n), 3);
    step();
    chk("mul_issue", out_valid, 1);
    chk("mul_op1", out_op1, 64'h55);
    idle();
    wb_valid = 1; wb_dst = 5'd5;
    step();
    idle();
    in_valid = 1; in_pc = 64'h408; in_instr = mk(5'd5, 5'd0, 5'd0); rf_q1 = 64'h77;
    step();
    chk("post_wb_op1", out_op1, 64'h77);

    // Same-cycle issue and writeback to x6: issue wins, x6 stays pending
    idle();
    in_valid = 1; in_pc = 64'h500; in_instr = mk(5'd1, 5'd1, 5'd6);
    in_regwrite = 1; in_lat = 4'd2; wb_valid = 1; wb_dst = 5'd6;
    step();
    idle();
    in_valid = 1; in_pc = 64'h504; in_instr = mk(5'd6, 5'd0, 5'd0);
    #1;
    chk("iss_wb_stall", stall_d, 1);
    step();
    idle();
    wb_valid = 1; wb_dst = 5'd6;
    step();

    // Hold freezes the stage; flush under hold still drops validity
    idle();
    in_valid = 1; in_pc = 64'h600; in_instr = mk(5'd1, 5'd2, 5'd9); in_regwrite = 1;
    rf_q1 = 64'h11; rf_q2 = 64'h22;
    step();
    in_pc = 64'h604; hold = 1; rf_q1 = 64'h33;
    step();
    chk("hold_pc", out_pc, 64'h600);
    chk("hold_valid", out_valid, 1);
    flush = 1;
    step();
    chk("hold_flush_valid", out_valid, 0);
    chk("hold_flush_op1", out_op1, 64'h11);

    // Reset while a consumer is stalled on a pending write
    idle();
    in_valid = 1; in_pc = 64'h700; in_instr = mk(5'd0, 5'd0, 5'd7);
    in_regwrite = 1; in_lat = 4'd5;
    step();
    in_instr = mk(5'd7, 5'd0, 5'd0); in_regwrite = 0; in_lat = '0;
    step();
    #1;
    chk("pre_rst_stall", stall_d, 1);
    reset = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_pc", out_pc, 0);
    chk("mid_rst_dst", out_dst, 0);
    chk("mid_rst_stall_cnt", stall_cnt, 0);
    chk("mid_rst_busy_clear", stall_d, 0);
    #2 reset = 0;
    model_reset();
    step();

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      idle();
      in_valid    = ($urandom_range(3) != 0);
      in_pc       = {$urandom, $urandom};
      in_instr    = $urandom;
      in_instr[19:15] = 5'($urandom_range(7));
      in_instr[24:20] = 5'($urandom_range(7));
      in_instr[11:7]  = 5'($urandom_range(7));
      in_regwrite = $urandom_range(1);
      in_lat      = 4'($urandom_range(4));
      rf_q1       = {$urandom, $urandom};
      rf_q2       = {$urandom, $urandom};
      for (int i = 0; i < NFWD; i++)
        set_fwd(i, $urandom_range(1), 5'($urandom_range(7)),
                ($urandom_range(3) != 0), {$urandom, $urandom});
      wb_valid = ($urandom_range(2) == 0);
      wb_dst   = 5'($urandom_range(7));
      hold     = ($urandom_range(4) == 0);
      flush    = ($urandom_range(7) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
